// File: rtl/gift_ise_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : gift_ise_pkg                                                   |
// | Purpose : Shared opcodes, FSM encoding and round-constant bit positions  |
// |           for the byte-serial GIFT-128 ISE blocks.                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package gift_ise_pkg;

  // Opcodes carried on operand A during a CMD beat
  localparam logic [7:0] OP_KEY        = 8'h01;  // load 128-bit round key
  localparam logic [7:0] OP_ARK        = 8'h02;  // load state, add round key
  localparam logic [7:0] OP_RCRST      = 8'h03;  // clear round-constant LFSR
  localparam logic [7:0] OP_ERR_RESULT = 8'hFF;  // result for unknown opcode

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_KLOAD   = 3'd1,
    ST_SLOAD   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_UNLOAD  = 3'd4
  } state_e;

  // Constant-addition bit positions. Entry 0 is the fixed bit 127; entries
  // 1..6 receive rc_next[0..5] respectively.
  localparam logic [6:0][6:0] CONST_BIT_IDX =
    {7'd23, 7'd19, 7'd15, 7'd11, 7'd7, 7'd3, 7'd127};

endpackage
`default_nettype wire

// File: rtl/gift_ark_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : gift_ark_core                                                  |
// | Purpose : Combinational GIFT-128 AddRoundKey: key/constant addition,     |
// |           key-schedule step and round-constant LFSR step.                |
// | Ports   : i_state[127:0]   permuted cipher state                         |
// |           i_key[127:0]     current round key (k7..k0, 16-bit words)      |
// |           i_rc[5:0]        current round-constant LFSR value             |
// |           o_out[127:0]     state with round key and constant added       |
// |           o_key_next       key for the following round                   |
// |           o_rc_next[5:0]   LFSR value used this round and kept next      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module gift_ark_core
  import gift_ise_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  input  logic [5:0]   i_rc,
  output logic [127:0] o_out,
  output logic [127:0] o_key_next,
  output logic [5:0]   o_rc_next
);

  logic [127:0] w_out;
  logic [5:0]   w_rc_next;
  logic [15:0]  w_k1;
  logic [15:0]  w_k0;

  // The LFSR advances before use, so the first round after a clear uses 0x01.
  assign w_rc_next = {i_rc[4:0], i_rc[5] ^ i_rc[4] ^ 1'b1};

  always_comb begin
    w_out = i_state;
    // U = k5||k4 goes into bit 2 of each nibble, V = k1||k0 into bit 1.
    for (int i = 0; i < 32; i++) begin
      w_out[4*i+2] = w_out[4*i+2] ^ i_key[64+i];
      w_out[4*i+1] = w_out[4*i+1] ^ i_key[i];
    end
    w_out[CONST_BIT_IDX[0]] = ~w_out[CONST_BIT_IDX[0]];
    for (int k = 1; k < 7; k++) begin
      w_out[CONST_BIT_IDX[k]] = w_out[CONST_BIT_IDX[k]] ^ w_rc_next[k-1];
    end
  end

  assign w_k1 = i_key[31:16];
  assign w_k0 = i_key[15:0];

  // k7' = k1 >>> 2, k6' = k0 >>> 12, remaining words shift down by two.
  assign o_key_next = {w_k1[1:0], w_k1[15:2], w_k0[11:0], w_k0[15:12], i_key[127:32]};
  assign o_out      = w_out;
  assign o_rc_next  = w_rc_next;

endmodule
`default_nettype wire

// File: rtl/gift_ark_ise.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : gift_ark_ise                                                   |
// | Purpose : Byte-serial GIFT-128 AddRoundKey instruction-set extension.    |
// |           Loads key or state two bytes per beat, adds round key and      |
// |           constant in one stall cycle, unloads the 16 result bytes.      |
// | Ports   : clk, rst        clock, async active-high reset                 |
// |           start           one handshake beat per asserted cycle          |
// |           a, b            operand bytes (a = opcode in CMD beat)         |
// |           sr / sr_out     status register pass-through                   |
// |           result          registered result byte                        |
// |           wait_req        stall request to the core                     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module gift_ark_ise
  import gift_ise_pkg::*;
#(
  parameter int NUM_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] sr,
  output logic [7:0] sr_out,
  output logic [7:0] result,
  output logic       wait_req
);

  localparam int BEAT_W = $clog2(NUM_BYTES / 2);
  localparam int U_W    = $clog2(NUM_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BYTES / 2 - 1);
  localparam logic [U_W-1:0]    U_FIRST   = U_W'(NUM_BYTES - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [U_W-1:0]      u_q, u_d;
  logic [127:0]        key_q, key_d;
  logic [127:0]        sreg_q, sreg_d;
  logic [127:0]        out_q, out_d;
  logic [5:0]          rc_q, rc_d;
  logic [7:0]          result_q, result_d;
  logic                wait_q, wait_d;

  logic [127:0]        w_core_out;
  logic [127:0]        w_core_key_next;
  logic [5:0]          w_core_rc_next;
  logic [U_W-1:0]      w_u_dec;
  logic                w_last_sload;

  gift_ark_core u_core (
    .i_state    (sreg_q),
    .i_key      (key_q),
    .i_rc       (rc_q),
    .o_out      (w_core_out),
    .o_key_next (w_core_key_next),
    .o_rc_next  (w_core_rc_next)
  );

  assign w_u_dec      = u_q - 1'b1;
  assign w_last_sload = (state_q == ST_SLOAD) && start && (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CMD;
      beat_q   <= '0;
      u_q      <= '0;
      key_q    <= '0;
      sreg_q   <= '0;
      out_q    <= '0;
      rc_q     <= '0;
      result_q <= 8'h00;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      u_q      <= u_d;
      key_q    <= key_d;
      sreg_q   <= sreg_d;
      out_q    <= out_d;
      rc_q     <= rc_d;
      result_q <= result_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CMD: begin
        if (start && (a == OP_KEY)) state_d = ST_KLOAD;
        if (start && (a == OP_ARK)) state_d = ST_SLOAD;
      end
      ST_KLOAD:   if (start && (beat_q == LAST_BEAT)) state_d = ST_CMD;
      ST_SLOAD:   if (w_last_sload) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_UNLOAD;
      ST_UNLOAD:  if (start && (u_q == U_W'(1))) state_d = ST_CMD;
      default:    state_d = ST_CMD;
    endcase
  end

  // Datapath and output register updates
  always_comb begin
    beat_d   = beat_q;
    u_d      = u_q;
    key_d    = key_q;
    sreg_d   = sreg_q;
    out_d    = out_q;
    rc_d     = rc_q;
    result_d = result_q;
    // Registered half of the stall: covers the COMPUTE cycle.
    wait_d   = w_last_sload;
    unique case (state_q)
      ST_CMD: begin
        if (start) begin
          beat_d = '0;
          unique case (a)
            OP_KEY, OP_ARK: result_d = 8'h00;
            OP_RCRST: begin
              result_d = 8'h00;
              rc_d     = 6'b0;
            end
            default: result_d = OP_ERR_RESULT;
          endcase
        end
      end
      ST_KLOAD: begin
        if (start) begin
          key_d[16*beat_q +: 16] = {b, a};
          beat_d = beat_q + 1'b1;
        end
      end
      ST_SLOAD: begin
        if (start) begin
          sreg_d[16*beat_q +: 16] = {b, a};
          beat_d = beat_q + 1'b1;
        end
      end
      ST_COMPUTE: begin
        out_d    = w_core_out;
        result_d = w_core_out[127:120];
        rc_d     = w_core_rc_next;
        key_d    = w_core_key_next;
        u_d      = U_FIRST;
      end
      ST_UNLOAD: begin
        if (start) begin
          result_d = out_q[8*w_u_dec +: 8];
          u_d      = w_u_dec;
        end
      end
      default: ;
    endcase
  end

  // Outputs: the last SLOAD beat stalls combinationally, COMPUTE via wait_q.
  assign wait_req = wait_q | w_last_sload;
  assign result   = result_q;
  assign sr_out   = sr;

endmodule
`default_nettype wire

// File: tb/tb_gift_ark_ise.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_gift_ark_ise                                                |
// | Purpose : Scoreboard bench for gift_ark_ise. Driver tasks push expected  |
// |           result / wait_req values tagged with the cycle they are due;   |
// |           a negedge monitor pops and compares them.                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_gift_ark_ise;
  import gift_ise_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sr;
  logic [7:0] sr_out;
  logic [7:0] result;
  logic       wait_req;
  logic       done = 1'b0;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    logic [7:0]  exp;
    logic        is_wait;
    logic [63:0] nm;
  } item_t;

  item_t sb_q[$];

  localparam logic [127:0] E_ZERO_R1 = 128'h8000_0000_0000_0000_0000_0000_0000_0008;
  localparam logic [127:0] E_ZERO_R2 = 128'h8000_0000_0000_0000_0000_0000_0000_0088;
  localparam logic [127:0] E_ONES_R1 = 128'hE666_6666_6666_6666_6666_6666_6666_666E;
  localparam logic [127:0] E_ONES_R2 = 128'hE666_6666_6666_6666_6666_6666_6666_66EE;
  localparam logic [127:0] E_K1_R1   = 128'h8000_0000_0000_0000_0000_0000_0000_000A;
  localparam logic [127:0] E_K1_R3   = 128'h8000_0000_0000_0000_0000_0000_0004_0888;

  gift_ark_ise #(.NUM_BYTES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .sr       (sr),
    .sr_out   (sr_out),
    .result   (result),
    .wait_req (wait_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole owner of the counters.
  always @(negedge clk) begin : mon
    item_t      it;
    logic [7:0] got;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      it  = sb_q.pop_front();
      got = it.is_wait ? {7'b0, wait_req} : result;
      total++;
      if (it.due != cyc || got !== it.exp) begin
        bad++;
        $display("FAIL %s: got=%02h expected=%02h (due cycle %0d, now %0d)",
                 it.nm, got, it.exp, it.due, cyc);
      end
    end
    total++;
    if (sr_out !== sr) begin
      bad++;
      $display("FAIL sr_out: got=%02h expected=%02h", sr_out, sr);
    end
    if (done) begin
      total++;
      if (sb_q.size() != 0) begin
        bad++;
        $display("FAIL drain: pending=%0d expected=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus: wait_req is checked in this cycle, result in the next.
  task automatic beat(input logic st, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] exp_res, input logic exp_w,
                      input logic [63:0] nm);
    start = st;
    a     = aa;
    b     = bb;
    sr    = 8'($urandom_range(0, 255));
    sb_q.push_back('{cyc, {7'b0, exp_w}, 1'b1, nm});
    sb_q.push_back('{cyc + 1, exp_res, 1'b0, nm});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reset asserted just after a clock edge and checked before the next one.
  task automatic do_reset();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    sb_q.push_back('{cyc, 8'h00, 1'b0, "rst_res"});
    sb_q.push_back('{cyc, 8'h00, 1'b1, "rst_wait"});
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic kload(input logic [127:0] k);
    beat(1'b1, OP_KEY, 8'h00, 8'h00, 1'b0, "kcmd");
    for (int j = 0; j < 8; j++)
      beat(1'b1, k[16*j +: 8], k[16*j+8 +: 8], 8'h00, 1'b0, "kload");
  endtask

  // Full ARK round; n_unl < 15 stops part-way through the unload.
  task automatic ark(input logic [127:0] st, input logic [127:0] ex, input int n_unl);
    beat(1'b1, OP_ARK, 8'h00, 8'h00, 1'b0, "acmd");
    for (int j = 0; j < 8; j++) begin
      if (j == 3) beat(1'b0, 8'hAA, 8'h55, 8'h00, 1'b0, "shold");
      beat(1'b1, st[16*j +: 8], st[16*j+8 +: 8], 8'h00, (j == 7), "sload");
    end
    // start during COMPUTE must be ignored
    beat(1'b1, OP_KEY, 8'h00, ex[127:120], 1'b1, "compute");
    for (int u = 15; u > 15 - n_unl; u--)
      beat(1'b1, 8'h00, 8'h00, ex[8*(u-1) +: 8], 1'b0, "unload");
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    sr    = 8'h00;
    do_reset();

    // Zero key, two rounds: rc 0x01 then 0x03
    kload('0);
    ark('0, E_ZERO_R1, 15);
    ark('0, E_ZERO_R2, 15);
    beat(1'b0, 8'h00, 8'h00, E_ZERO_R2[7:0], 1'b0, "uhold");

    // All-ones key stays all-ones across rounds
    do_reset();
    kload('1);
    ark('0, E_ONES_R1, 15);
    ark('0, E_ONES_R2, 15);

    // Single key bit walks through the schedule
    do_reset();
    kload(128'h1);
    ark('0, E_K1_R1, 15);
    ark('0, E_ZERO_R2, 15);
    ark('0, E_K1_R3, 15);

    // Bad opcode, then rc clear reproduces the first-round constant
    do_reset();
    kload('0);
    ark('0, E_ZERO_R1, 15);
    beat(1'b1, 8'h55, 8'h00, OP_ERR_RESULT, 1'b0, "badop");
    beat(1'b0, 8'h00, 8'h00, OP_ERR_RESULT, 1'b0, "cmdhold");
    beat(1'b1, OP_RCRST, 8'h00, 8'h00, 1'b0, "rcrst");
    ark('0, E_ZERO_R1, 15);

    // Reset mid-SLOAD (beat 4)
    do_reset();
    beat(1'b1, OP_ARK, 8'h00, 8'h00, 1'b0, "acmd");
    for (int j = 0; j < 4; j++)
      beat(1'b1, 8'h5A, 8'hC3, 8'h00, 1'b0, "sload");
    do_reset();

    // Reset mid-UNLOAD (u=7) after a nonzero key and rc advance
    kload('1);
    ark('0, E_ONES_R1, 8);
    do_reset();
    ark('0, E_ZERO_R1, 15);

    beat(1'b0, 8'h00, 8'h00, E_ZERO_R1[7:0], 1'b0, "idle");
    beat(1'b0, 8'h00, 8'h00, E_ZERO_R1[7:0], 1'b0, "idle");
    done = 1'b1;
  end

endmodule
`default_nettype wire
